// File: rtl/lv1_il_pkg.sv
// Shared types and address helpers for the L1 instruction-cache fill controller.
// Widths are carried as arguments so one set of helpers serves every parameterisation.
package lv1_il_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REQ,
    FILL,
    RESP
  } state_e;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  localparam int MAX_ADDR_WID = 64;
  typedef logic [MAX_ADDR_WID-1:0] wide_addr_t;

  function automatic wide_addr_t tag_of(input wide_addr_t  addr,
                                        input int unsigned index_wid,
                                        input int unsigned word_wid);
    return addr >> (index_wid + word_wid);
  endfunction

  // Word address of word 0 of the line holding addr.
  function automatic wide_addr_t line_addr(input wide_addr_t  addr,
                                           input int unsigned word_wid);
    return (addr >> word_wid) << word_wid;
  endfunction

endpackage

// File: rtl/lv1_il_victim_sel.sv
// Victim way selection for a miss: lowest-numbered invalid way, else the external LRU choice.
module lv1_il_victim_sel
  import lv1_il_pkg::*;
#(
  parameter int ASSOC     = 4,
  parameter int ASSOC_WID = 2
) (
  input  logic [ASSOC-1:0]     i_valid,
  input  logic [ASSOC_WID-1:0] i_lru,
  output logic [ASSOC_WID-1:0] o_victim
);

  // NOTE: o_victim gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    o_victim = i_lru;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (i_valid[ASSOC_WID'(w)] == INVALID) o_victim = ASSOC_WID'(w);
    end
  end

endmodule

// File: rtl/icache_fill_ctrl_lv1_il.sv
// L1 instruction-cache controller: tag lookup, multi-beat line fill from LV2 with
// first-free/LRU replacement, registered CPU response and single-cycle flush.
module icache_fill_ctrl_lv1_il
  import lv1_il_pkg::*;
#(
  parameter int ASSOC      = 4,
  parameter int ASSOC_WID  = 2,
  parameter int NUM_SETS   = 256,
  parameter int INDEX_WID  = 8,
  parameter int LINE_WORDS = 4,
  parameter int WORD_WID   = 2,
  parameter int DATA_WID   = 32,
  parameter int ADDR_WID   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_rd,
  input  logic [ADDR_WID-1:0]  addr_bus_cpu_lv1,
  inout  wire  [DATA_WID-1:0]  data_bus_cpu_lv1,
  output logic                 data_in_bus_cpu_lv1_il,
  input  logic                 flush,
  output logic                 bus_lv1_lv2_req_proc_il,
  input  logic                 bus_lv1_lv2_gnt_proc,
  output logic                 lv2_rd,
  output logic [ADDR_WID-1:0]  addr_bus_lv1_lv2,
  input  logic [DATA_WID-1:0]  data_bus_lv1_lv2,
  input  logic                 data_in_bus_lv1_lv2,
  input  logic [ASSOC_WID-1:0] lru_replacement_proc,
  output logic [ASSOC_WID-1:0] blk_accessed_main,
  output logic                 lru_update
);

  localparam int TAG_WID  = ADDR_WID - INDEX_WID - WORD_WID;
  localparam int CNT_WID  = (WORD_WID > 0) ? WORD_WID : 1;
  localparam int TDEPTH   = NUM_SETS * ASSOC;
  localparam int DDEPTH   = NUM_SETS * ASSOC * LINE_WORDS;
  localparam int TIDX_WID = (TDEPTH > 1) ? $clog2(TDEPTH) : 1;
  localparam int DIDX_WID = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;

  state_e               r_state;
  state_e               w_next_state;
  logic [ADDR_WID-1:0]  r_addr;
  logic [CNT_WID-1:0]   r_beat_cnt;
  logic [ASSOC_WID-1:0] r_way;
  logic                 r_flush_pend;
  logic                 r_cpu_valid;
  logic [DATA_WID-1:0]  r_cpu_data;
  logic                 r_lru_update;
  logic [ASSOC_WID-1:0] r_blk;
  logic [ASSOC-1:0]     r_valid   [NUM_SETS];
  logic [TAG_WID-1:0]   r_tag_mem [TDEPTH];
  logic [DATA_WID-1:0]  r_data_mem[DDEPTH];

  logic [INDEX_WID-1:0] w_index;
  logic [TAG_WID-1:0]   w_tag;
  logic [CNT_WID-1:0]   w_word_off;
  logic [ASSOC-1:0]     w_set_valid;
  logic                 w_hit;
  logic [ASSOC_WID-1:0] w_hit_way;
  logic [ASSOC_WID-1:0] w_victim;
  logic                 w_flush_now;
  logic                 w_start;
  logic                 w_fill_beat;
  logic                 w_last_beat;
  logic                 w_req;
  logic                 w_lv2_rd;

  function automatic logic [TIDX_WID-1:0] tag_idx(input logic [INDEX_WID-1:0] idx,
                                                  input logic [ASSOC_WID-1:0] way);
    return TIDX_WID'(int'(idx) * ASSOC + int'(way));
  endfunction

  function automatic logic [DIDX_WID-1:0] data_idx(input logic [INDEX_WID-1:0] idx,
                                                   input logic [ASSOC_WID-1:0] way,
                                                   input logic [CNT_WID-1:0]   word);
    return DIDX_WID'((int'(idx) * ASSOC + int'(way)) * LINE_WORDS + int'(word));
  endfunction

  assign w_index     = INDEX_WID'(r_addr >> WORD_WID);
  assign w_tag       = TAG_WID'(tag_of(wide_addr_t'(r_addr), INDEX_WID, WORD_WID));
  assign w_word_off  = r_addr[CNT_WID-1:0] & CNT_WID'(LINE_WORDS - 1);
  assign w_set_valid = r_valid[w_index];
  assign w_flush_now = flush || r_flush_pend;
  // A pending response blocks restart so the still-held cpu_rd is not taken as a new fetch.
  assign w_start     = cpu_rd && !r_cpu_valid && !w_flush_now;
  assign w_fill_beat = (r_state == FILL) && data_in_bus_lv1_lv2;
  assign w_last_beat = (r_beat_cnt == CNT_WID'(LINE_WORDS - 1));

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (w_set_valid[ASSOC_WID'(w)] == VALID &&
          r_tag_mem[tag_idx(w_index, ASSOC_WID'(w))] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = ASSOC_WID'(w);
      end
    end
  end

  lv1_il_victim_sel #(
    .ASSOC     (ASSOC),
    .ASSOC_WID (ASSOC_WID)
  ) u_victim_sel (
    .i_valid  (w_set_valid),
    .i_lru    (lru_replacement_proc),
    .o_victim (w_victim)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_lv2_rd     = 1'b0;
    unique case (r_state)
      IDLE:   if (w_start) w_next_state = LOOKUP;
      LOOKUP: w_next_state = w_hit ? RESP : REQ;
      REQ: begin
        w_req = 1'b1;
        if (bus_lv1_lv2_gnt_proc) w_next_state = FILL;
      end
      FILL: begin
        // Grant is not re-checked here: once the fill starts it runs to the last beat.
        w_req    = 1'b1;
        w_lv2_rd = 1'b1;
        if (w_fill_beat && w_last_beat) w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_beat_cnt   <= '0;
      r_way        <= '0;
      r_flush_pend <= 1'b0;
      r_cpu_valid  <= 1'b0;
      r_lru_update <= 1'b0;
      r_blk        <= '0;
      r_valid      <= '{default: '0};
    end else begin
      r_lru_update <= 1'b0;
      r_cpu_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_flush_now) begin
            r_valid      <= '{default: '0};
            r_flush_pend <= 1'b0;
          end else if (w_start) begin
            r_addr <= addr_bus_cpu_lv1;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_way        <= w_hit_way;
            r_lru_update <= 1'b1;
            r_blk        <= w_hit_way;
          end else begin
            // The victim stays invalid until its last beat lands, so an aborted fill never hits.
            r_way                      <= w_victim;
            r_valid[w_index][w_victim] <= INVALID;
          end
        end
        FILL: begin
          if (w_fill_beat) begin
            if (w_last_beat) begin
              r_beat_cnt              <= '0;
              r_valid[w_index][r_way] <= VALID;
              r_lru_update            <= 1'b1;
              r_blk                   <= r_way;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        RESP:    r_cpu_valid <= cpu_rd;
        default: ;
      endcase
      if (flush && r_state != IDLE) r_flush_pend <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset so they map onto RAM; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_fill_beat) begin
      r_data_mem[data_idx(w_index, r_way, r_beat_cnt)] <= data_bus_lv1_lv2;
      if (w_last_beat) r_tag_mem[tag_idx(w_index, r_way)] <= w_tag;
    end
    if (r_state == RESP) r_cpu_data <= r_data_mem[data_idx(w_index, r_way, w_word_off)];
  end

  assign data_bus_cpu_lv1        = r_cpu_valid ? r_cpu_data : 'z;
  assign data_in_bus_cpu_lv1_il  = r_cpu_valid;
  assign bus_lv1_lv2_req_proc_il = w_req;
  assign lv2_rd                  = w_lv2_rd;
  assign addr_bus_lv1_lv2        = w_lv2_rd ? ADDR_WID'(line_addr(wide_addr_t'(r_addr), WORD_WID)) : 'z;
  assign lru_update              = r_lru_update;
  assign blk_accessed_main       = r_blk;

endmodule

// File: tb/tb_icache_fill_ctrl_lv1_il.sv
// Directed bench for icache_fill_ctrl_lv1_il: cold miss, hit, full-set replacement,
// flush during fill, reset mid-fill, beat gaps with dropped fetch, flush racing a fetch.
module tb_icache_fill_ctrl_lv1_il;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0;
  logic [31:0] cpu_addr = '0;
  wire  [31:0] cpu_data;
  logic        cpu_valid;
  logic        flush = 1'b0;
  logic        req;
  logic        gnt = 1'b0;
  logic        lv2_rd;
  wire  [31:0] lv2_addr;
  logic [31:0] ddata = '0;
  logic        dvalid = 1'b0;
  logic [1:0]  lru = 2'd0;
  logic [1:0]  blk;
  logic        lru_upd;

  int n_vec = 0;
  int n_mis = 0;

  icache_fill_ctrl_lv1_il dut (
    .clk                     (clk),
    .rst                     (rst),
    .cpu_rd                  (cpu_rd),
    .addr_bus_cpu_lv1        (cpu_addr),
    .data_bus_cpu_lv1        (cpu_data),
    .data_in_bus_cpu_lv1_il  (cpu_valid),
    .flush                   (flush),
    .bus_lv1_lv2_req_proc_il (req),
    .bus_lv1_lv2_gnt_proc    (gnt),
    .lv2_rd                  (lv2_rd),
    .addr_bus_lv1_lv2        (lv2_addr),
    .data_bus_lv1_lv2        (ddata),
    .data_in_bus_lv1_lv2     (dvalid),
    .lru_replacement_proc    (lru),
    .blk_accessed_main       (blk),
    .lru_update              (lru_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after the LOOKUP edge (RESP on a hit, REQ on a miss).
  task automatic start_read(input logic [31:0] a);
    cpu_rd   = 1'b1;
    cpu_addr = a;
    tick();
    tick();
  endtask

  task automatic hit_read(input string tag, input logic [31:0] a, input logic [1:0] way,
                          input logic [31:0] exp);
    start_read(a);
    @(negedge clk);
    check({tag, " no req"}, 32'(req), 32'd0);
    check({tag, " lru_update"}, 32'(lru_upd), 32'd1);
    check({tag, " hit way"}, 32'(blk), 32'(way));
    check({tag, " valid not early"}, 32'(cpu_valid), 32'd0);
    tick();
    @(negedge clk);
    check({tag, " valid"}, 32'(cpu_valid), 32'd1);
    check({tag, " data"}, cpu_data, exp);
    check({tag, " lru pulse ends"}, 32'(lru_upd), 32'd0);
    tick();
    cpu_rd = 1'b0;
    tick();
  endtask

  // Entered one cycle into REQ; drives grant and LINE_WORDS beats, checks install and response.
  task automatic miss_fill(input string tag, input logic [31:0] line, input int gnt_wait,
                           input logic [31:0] d0, input int gap, input logic [1:0] way,
                           input int drop_beat, input int flush_beat, input logic [31:0] exp);
    logic kept;
    kept = (drop_beat < 0);
    @(negedge clk);
    check({tag, " req"}, 32'(req), 32'd1);
    check({tag, " lv2_rd before gnt"}, 32'(lv2_rd), 32'd0);
    check({tag, " lru quiet in REQ"}, 32'(lru_upd), 32'd0);
    repeat (gnt_wait - 1) tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    @(negedge clk);
    check({tag, " lv2_rd"}, 32'(lv2_rd), 32'd1);
    check({tag, " req in FILL"}, 32'(req), 32'd1);
    check({tag, " line addr"}, lv2_addr, line);
    check({tag, " lru quiet in FILL"}, 32'(lru_upd), 32'd0);
    for (int b = 0; b < 4; b++) begin
      repeat (gap) begin
        dvalid = 1'b0;
        tick();
      end
      dvalid = 1'b1;
      ddata  = d0 + 32'(b);
      if (b == drop_beat) cpu_rd = 1'b0;
      flush = (b == flush_beat);
      tick();
      dvalid = 1'b0;
      flush  = 1'b0;
    end
    @(negedge clk);
    check({tag, " fill lru_update"}, 32'(lru_upd), 32'd1);
    check({tag, " victim way"}, 32'(blk), 32'(way));
    check({tag, " req dropped"}, 32'(req), 32'd0);
    check({tag, " lv2_rd dropped"}, 32'(lv2_rd), 32'd0);
    tick();
    @(negedge clk);
    check({tag, " cpu valid"}, 32'(cpu_valid), 32'(kept));
    if (kept) check({tag, " cpu data"}, cpu_data, exp);
    check({tag, " lru pulse ends"}, 32'(lru_upd), 32'd0);
    tick();
    cpu_rd = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    @(negedge clk);
    check("rst req", 32'(req), 32'd0);
    check("rst lv2_rd", 32'(lv2_rd), 32'd0);
    check("rst lru_update", 32'(lru_upd), 32'd0);
    check("rst blk", 32'(blk), 32'd0);
    check("rst cpu valid", 32'(cpu_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss and hit
    start_read(32'h0000_0105);
    miss_fill("t1", 32'h104, 3, 32'hA0, 0, 2'd0, -1, -1, 32'hA1);
    hit_read("t2", 32'h105, 2'd0, 32'hA1);

    // Fill the rest of set 0x41 (free ways win over LRU), then replace the LRU way
    lru = 2'd3;
    start_read(32'h507);
    miss_fill("t3 tag1", 32'h504, 1, 32'hB0, 0, 2'd1, -1, -1, 32'hB3);
    start_read(32'h906);
    miss_fill("t3 tag2", 32'h904, 2, 32'hC0, 0, 2'd2, -1, -1, 32'hC2);
    start_read(32'hD04);
    miss_fill("t3 tag3", 32'hD04, 1, 32'hD0, 0, 2'd3, -1, -1, 32'hD0);
    lru = 2'd2;
    start_read(32'h1105);
    miss_fill("t3 tag4", 32'h1104, 1, 32'hE0, 0, 2'd2, -1, -1, 32'hE1);
    hit_read("t3 hit tag4", 32'h1104, 2'd2, 32'hE0);
    hit_read("t3 hit tag3", 32'hD07, 2'd3, 32'hD3);
    hit_read("t3 hit tag0", 32'h105, 2'd0, 32'hA1);
    lru = 2'd1;
    start_read(32'h905);
    miss_fill("t3 evicted", 32'h904, 1, 32'hF0, 0, 2'd1, -1, -1, 32'hF1);

    // Flush during fill: fill completes, then everything misses
    start_read(32'h2002);
    miss_fill("t4 fill", 32'h2000, 2, 32'h50, 0, 2'd0, -1, 1, 32'h52);
    start_read(32'h2002);
    miss_fill("t4 reread", 32'h2000, 1, 32'h60, 0, 2'd0, -1, -1, 32'h62);
    start_read(32'h105);
    miss_fill("t4 old line", 32'h104, 1, 32'hA0, 0, 2'd0, -1, -1, 32'hA1);

    // Reset after two of four beats
    start_read(32'h3003);
    @(negedge clk);
    check("t5 req", 32'(req), 32'd1);
    gnt = 1'b1;
    tick();
    gnt    = 1'b0;
    dvalid = 1'b1;
    ddata  = 32'h70;
    tick();
    ddata = 32'h71;
    tick();
    dvalid = 1'b0;
    rst    = 1'b1;
    cpu_rd = 1'b0;
    #1;
    check("t5 req at rst", 32'(req), 32'd0);
    check("t5 lv2_rd at rst", 32'(lv2_rd), 32'd0);
    check("t5 lru at rst", 32'(lru_upd), 32'd0);
    check("t5 valid at rst", 32'(cpu_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    start_read(32'h3003);
    miss_fill("t5 after rst", 32'h3000, 2, 32'h78, 0, 2'd0, -1, -1, 32'h7B);

    // Beat gaps with fetch dropped mid-fill: installed but not returned
    lru = 2'd3;
    start_read(32'h4001);
    miss_fill("t6 gaps", 32'h4000, 1, 32'h80, 2, 2'd1, 1, -1, 32'h81);
    hit_read("t6 hit", 32'h4001, 2'd1, 32'h81);

    // Flush and fetch in the same IDLE cycle: flush first, fetch next cycle misses
    cpu_rd   = 1'b1;
    cpu_addr = 32'h4001;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("t7 idle on flush", 32'(req), 32'd0);
    tick();
    tick();
    miss_fill("t7 miss", 32'h4000, 1, 32'h90, 0, 2'd0, -1, -1, 32'h91);
    hit_read("t7 hit", 32'h4003, 2'd0, 32'h93);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
